// File: rtl/pkg_opengpu.sv
// pkg_opengpu -- shared constants and types for the L1 instruction fetch path.
//
// Contents:
//    NUM_FETCH_REQ         default number of fetch requesters (warp fetch units)
//    FETCH_TIMEOUT_CYCLES  default cycles allowed from cache acceptance to response
//    ADDR_WIDTH            fetch address width
//    INSTR_WIDTH           instruction width returned by the cache
//    fetch_arb_state_t     arbiter FSM states (ARB, WAIT)

package pkg_opengpu;

   localparam int NUM_FETCH_REQ        = 4;
   localparam int FETCH_TIMEOUT_CYCLES = 256;
   localparam int ADDR_WIDTH           = 32;
   localparam int INSTR_WIDTH          = 32;

   typedef enum logic [0:0] {
      ARB  = 1'b0,
      WAIT = 1'b1
   } fetch_arb_state_t;

endpackage

// File: rtl/l1i_fetch_arbiter_if.sv
// l1i_fetch_arbiter_if -- request/response bus between the fetch arbiter and
// the L1 instruction cache.
//
// Signals:
//    req_valid   arbiter -> cache  request strobe
//    req_addr    arbiter -> cache  request address
//    ready       cache -> arbiter  cache idle, request accepted when req_valid & ready
//    resp_valid  cache -> arbiter  response strobe
//    resp_hit    cache -> arbiter  response was a hit
//    resp_instr  cache -> arbiter  response instruction
//
// Modports: master (arbiter side), slave (cache side).

interface l1i_fetch_arbiter_if;
   import pkg_opengpu::*;

   logic                   req_valid;
   logic [ADDR_WIDTH-1:0]  req_addr;
   logic                   ready;
   logic                   resp_valid;
   logic                   resp_hit;
   logic [INSTR_WIDTH-1:0] resp_instr;

   modport master (
      output req_valid, req_addr,
      input  ready, resp_valid, resp_hit, resp_instr
   );

   modport slave (
      input  req_valid, req_addr,
      output ready, resp_valid, resp_hit, resp_instr
   );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter -- purely combinational round-robin pick.
//
// Ports:
//    req    N-bit request vector
//    ptr    index where the search starts (highest priority this cycle)
//    grant  one-hot grant of the first request at or after ptr, wrapping
//    idx    binary index of the granted request
//    any    at least one request present

module rr_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx,
   output logic         any
);

   logic [W-1:0] pos;

   // Walk the requesters starting at ptr; the first hit wins and later
   // candidates are masked by 'any'.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = W'((int'(ptr) + k) % N);
         if (!any && req[pos]) begin
            any        = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end

endmodule

// File: rtl/l1i_fetch_arbiter.sv
// l1i_fetch_arbiter -- round-robin arbiter in front of the L1 instruction
// cache with at most one cache request outstanding.
//
// Ports:
//    clk, rst_n         clock; asynchronous active-low reset
//    fetch_req_valid    per-requester fetch request
//    fetch_req_addr     per-requester fetch address
//    fetch_req_ready    one-hot grant (combinational)
//    fetch_flush        per-requester cancel (branch redirect)
//    fetch_resp_valid   one-hot response strobe to the owning requester
//    fetch_resp_instr   response instruction (shared bus)
//    fetch_resp_hit     response was a cache hit
//    ic                 cache bus (l1i_fetch_arbiter_if.master)
//    err_timeout        one-cycle pulse when the cache fails to answer in time
//    stat_grants        per-requester grant counters
//
// Build option: define FETCH_ARB_STATS_EN to implement the stat_grants
// counters; otherwise stat_grants is tied to zero and no counters exist.

module l1i_fetch_arbiter
   import pkg_opengpu::*;
#(
   parameter int NUM_REQ        = NUM_FETCH_REQ,
   parameter int TIMEOUT_CYCLES = FETCH_TIMEOUT_CYCLES
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_REQ-1:0]                 fetch_req_valid,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] fetch_req_addr,
   output logic [NUM_REQ-1:0]                 fetch_req_ready,
   input  logic [NUM_REQ-1:0]                 fetch_flush,
   output logic [NUM_REQ-1:0]                 fetch_resp_valid,
   output logic [INSTR_WIDTH-1:0]             fetch_resp_instr,
   output logic                               fetch_resp_hit,
   l1i_fetch_arbiter_if.master                ic,
   output logic                               err_timeout,
   output logic [NUM_REQ-1:0][31:0]           stat_grants
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = 16;

   fetch_arb_state_t state_q, state_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0] owner_q, owner_d;
   logic             drop_q, drop_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] win_grant;
   logic [PTR_W-1:0]   win_idx;
   logic               win_any;
   logic [PTR_W-1:0]   next_ptr;

   // A requester being redirected in the same cycle is not worth fetching for.
   assign eligible = fetch_req_valid & ~fetch_flush;

   rr_arbiter #(
      .N (NUM_REQ),
      .W (PTR_W)
   ) u_rr (
      .req   (eligible),
      .ptr   (rr_ptr_q),
      .grant (win_grant),
      .idx   (win_idx),
      .any   (win_any)
   );

   // NUM_REQ need not be a power of two, so wrap explicitly.
   assign next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         drop_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         drop_q   <= drop_d;
         count_q  <= count_d;
      end
   end

   // Grant outputs are qualified with rst_n so nothing reaches the cache or
   // the requesters while reset is held, even with requests already pending.
   // In WAIT a flush arriving together with the response must suppress it,
   // hence the direct fetch_flush term next to the registered drop flag.
   // A response in the timeout cycle takes priority over the timeout.
   always_comb begin
      state_d          = state_q;
      rr_ptr_d         = rr_ptr_q;
      owner_d          = owner_q;
      drop_d           = drop_q;
      count_d          = count_q;
      ic.req_valid     = 1'b0;
      ic.req_addr      = '0;
      fetch_req_ready  = '0;
      fetch_resp_valid = '0;
      fetch_resp_instr = '0;
      fetch_resp_hit   = 1'b0;
      err_timeout      = 1'b0;
      case (state_q)
         ARB: begin
            if (rst_n && ic.ready && win_any) begin
               ic.req_valid    = 1'b1;
               ic.req_addr     = fetch_req_addr[win_idx];
               fetch_req_ready = win_grant;
               state_d         = WAIT;
               owner_d         = win_idx;
               rr_ptr_d        = next_ptr;
               drop_d          = 1'b0;
               count_d         = '0;
            end
         end
         WAIT: begin
            count_d = count_q + CNT_W'(1);
            if (fetch_flush[owner_q]) begin
               drop_d = 1'b1;
            end
            if (ic.resp_valid) begin
               if (!drop_q && !fetch_flush[owner_q]) begin
                  fetch_resp_valid[owner_q] = 1'b1;
                  fetch_resp_instr          = ic.resp_instr;
                  fetch_resp_hit            = ic.resp_hit;
               end
               state_d = ARB;
            end else if (count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               err_timeout = 1'b1;
               state_d     = ARB;
            end
         end
         default: state_d = ARB;
      endcase
   end

`ifdef FETCH_ARB_STATS_EN
   logic [NUM_REQ-1:0][31:0] stat_q;

   // ic.req_valid is only raised together with ic.ready, so it marks a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q <= '0;
      end else if (ic.req_valid) begin
         stat_q[win_idx] <= stat_q[win_idx] + 32'd1;
      end
   end

   assign stat_grants = stat_q;
`else
   assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_l1i_fetch_arbiter.sv
// tb_l1i_fetch_arbiter -- self-checking bench for l1i_fetch_arbiter.
// A transaction-level model (busy flag, grant timestamp, cancel flag) predicts
// every output each cycle; directed scenarios add fixed expectations.
// Honours FETCH_ARB_STATS_EN for the expected stat_grants values.

module tb_l1i_fetch_arbiter;
   import pkg_opengpu::*;

   localparam int N   = 4;
   localparam int PW  = 2;
   localparam int TMO = 8;
   localparam int VW  = 2*N + ADDR_WIDTH + INSTR_WIDTH + 3;

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic [N-1:0]                 fetch_req_valid;
   logic [N-1:0][ADDR_WIDTH-1:0] fetch_req_addr;
   logic [N-1:0]                 fetch_req_ready;
   logic [N-1:0]                 fetch_flush;
   logic [N-1:0]                 fetch_resp_valid;
   logic [INSTR_WIDTH-1:0]       fetch_resp_instr;
   logic                         fetch_resp_hit;
   logic                         err_timeout;
   logic [N-1:0][31:0]           stat_grants;

   l1i_fetch_arbiter_if ic_bus();

   l1i_fetch_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fetch_req_valid  (fetch_req_valid),
      .fetch_req_addr   (fetch_req_addr),
      .fetch_req_ready  (fetch_req_ready),
      .fetch_flush      (fetch_flush),
      .fetch_resp_valid (fetch_resp_valid),
      .fetch_resp_instr (fetch_resp_instr),
      .fetch_resp_hit   (fetch_resp_hit),
      .ic               (ic_bus),
      .err_timeout      (err_timeout),
      .stat_grants      (stat_grants)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   // Reference model state
   bit          m_busy;
   int          m_owner;
   int          m_ptr;
   int          m_win;
   bit          m_cancel;
   int unsigned m_gcyc;
   int unsigned m_now;
   bit [31:0]   m_stats [N];

   logic [N-1:0]             e_ready, e_rv;
   logic                     e_icv, e_hit, e_to;
   logic [ADDR_WIDTH-1:0]    e_addr;
   logic [INSTR_WIDTH-1:0]   e_instr;
   logic [VW-1:0]            e_vec, act_vec;
   logic [N-1:0][31:0]       e_stats;

   int total = 0;
   int bad   = 0;

   assign act_vec = {fetch_req_ready, ic_bus.req_valid, ic_bus.req_addr,
                     fetch_resp_valid, fetch_resp_instr, fetch_resp_hit, err_timeout};

   task automatic model_reset();
      m_busy   = 1'b0;
      m_owner  = 0;
      m_ptr    = 0;
      m_cancel = 1'b0;
      m_gcyc   = 0;
      for (int i = 0; i < N; i++) m_stats[i] = '0;
   endtask

   // Expected outputs for the current inputs and model state.
   task automatic model_comb();
      e_ready = '0; e_icv = 1'b0; e_addr = '0; e_rv = '0;
      e_instr = '0; e_hit = 1'b0; e_to = 1'b0; m_win = -1;
      if (rst_n) begin
         if (!m_busy) begin
            if (ic_bus.ready) begin
               for (int k = 0; k < N; k++) begin
                  if (m_win < 0 && fetch_req_valid[PW'((m_ptr + k) % N)] &&
                      !fetch_flush[PW'((m_ptr + k) % N)])
                     m_win = (m_ptr + k) % N;
               end
            end
            if (m_win >= 0) begin
               e_icv             = 1'b1;
               e_addr            = fetch_req_addr[PW'(m_win)];
               e_ready[PW'(m_win)] = 1'b1;
            end
         end else begin
            if (ic_bus.resp_valid) begin
               if (!m_cancel && !fetch_flush[PW'(m_owner)]) begin
                  e_rv[PW'(m_owner)] = 1'b1;
                  e_instr            = ic_bus.resp_instr;
                  e_hit              = ic_bus.resp_hit;
               end
            end else if (int'(m_now - m_gcyc) == TMO) begin
               e_to = 1'b1;
            end
         end
      end
      e_vec = {e_ready, e_icv, e_addr, e_rv, e_instr, e_hit, e_to};
      for (int i = 0; i < N; i++) begin
`ifdef FETCH_ARB_STATS_EN
         e_stats[PW'(i)] = m_stats[i];
`else
         e_stats[PW'(i)] = '0;
`endif
      end
   endtask

   // Model state update at the clock edge, using the inputs of that cycle.
   task automatic model_seq();
      if (!rst_n) begin
         model_reset();
      end else if (!m_busy) begin
         if (m_win >= 0) begin
            m_busy   = 1'b1;
            m_owner  = m_win;
            m_ptr    = (m_win + 1) % N;
            m_cancel = 1'b0;
            m_gcyc   = m_now;
            m_stats[m_win] = m_stats[m_win] + 32'd1;
         end
      end else begin
         if (fetch_flush[PW'(m_owner)]) m_cancel = 1'b1;
         if (ic_bus.resp_valid || e_to) m_busy = 1'b0;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      m_now = cyc;
      model_comb();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      model_seq();
   endtask

   task automatic clear_inputs();
      fetch_req_valid   = '0;
      fetch_flush       = '0;
      fetch_req_addr    = '0;
      ic_bus.ready      = 1'b0;
      ic_bus.resp_valid = 1'b0;
      ic_bus.resp_hit   = 1'b0;
      ic_bus.resp_instr = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      clear_inputs();
      fetch_req_valid   = '1;
      fetch_req_addr[0] = 32'hDEAD_0000;
      ic_bus.ready      = 1'b1;
      ic_bus.resp_valid = 1'b1;
      ic_bus.resp_instr = 32'h1234_5678;
      settle();
      total++;
      if (act_vec !== e_vec) begin
         bad++;
         $display("[TB] FAIL reset_outputs got=%h want=%h", act_vec, e_vec);
      end
      total++;
      if (ic_bus.req_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_ic_req_valid got=%b want=0", ic_bus.req_valid);
      end
      total++;
      if (stat_grants !== '0) begin
         bad++;
         $display("[TB] FAIL reset_stats got=%h want=0", stat_grants);
      end
      advance();
      clear_inputs();
      rst_n = 1'b1;
      settle();
      total++;
      if (act_vec !== '0) begin
         bad++;
         $display("[TB] FAIL reset_release_idle got=%h want=0", act_vec);
      end
      advance();
   endtask

   task automatic test_rr_pair();
      do_reset();
      fetch_req_addr[0] = 32'h0000_0100;
      fetch_req_addr[2] = 32'h0000_0200;
      fetch_req_valid   = 4'b0101;
      ic_bus.ready      = 1'b1;
      settle();
      total++;
      if (fetch_req_ready !== 4'b0001 || ic_bus.req_addr !== 32'h0000_0100) begin
         bad++;
         $display("[TB] FAIL rr_pair_first ready=%b addr=%h want 0001/00000100",
                  fetch_req_ready, ic_bus.req_addr);
      end
      advance();
      fetch_req_valid   = 4'b0100;
      ic_bus.resp_valid = 1'b1;
      ic_bus.resp_hit   = 1'b1;
      ic_bus.resp_instr = 32'hCAFE_0001;
      settle();
      total++;
      if (act_vec !== e_vec || fetch_resp_valid !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL rr_pair_resp got=%h want=%h", act_vec, e_vec);
      end
      advance();
      ic_bus.resp_valid = 1'b0;
      settle();
      total++;
      if (fetch_req_ready !== 4'b0100 || act_vec !== e_vec) begin
         bad++;
         $display("[TB] FAIL rr_pair_second ready=%b want=0100", fetch_req_ready);
      end
      advance();
      fetch_req_valid   = 4'b0000;
      ic_bus.resp_valid = 1'b1;
      settle();
      advance();
      ic_bus.resp_valid = 1'b0;
      fetch_req_valid   = 4'b1111;
      settle();
      total++;
      if (fetch_req_ready !== 4'b1000) begin
         bad++;
         $display("[TB] FAIL rr_pair_ptr3 ready=%b want=1000", fetch_req_ready);
      end
      advance();
   endtask

   task automatic test_back_to_back();
      int order[$];
      int exp_order[5] = '{0, 1, 2, 3, 0};
      do_reset();
      fetch_req_valid = '1;
      ic_bus.ready    = 1'b1;
      for (int r = 0; r < N; r++) fetch_req_addr[PW'(r)] = $urandom;
      for (int i = 0; i < 10; i++) begin
         ic_bus.resp_valid = m_busy;
         ic_bus.resp_hit   = 1'b1;
         ic_bus.resp_instr = $urandom;
         settle();
         total++;
         if (act_vec !== e_vec) begin
            bad++;
            $display("[TB] FAIL b2b_cycle%0d got=%h want=%h", i, act_vec, e_vec);
         end
         for (int r = 0; r < N; r++) if (fetch_req_ready[PW'(r)]) order.push_back(r);
         advance();
      end
      total++;
      if (order.size() != 5) begin
         bad++;
         $display("[TB] FAIL b2b_grant_count got=%0d want=5", order.size());
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (i >= order.size() || order[i] != exp_order[i]) begin
            bad++;
            $display("[TB] FAIL b2b_order[%0d] got=%0d want=%0d", i,
                     (i < order.size()) ? order[i] : -1, exp_order[i]);
         end
      end
      clear_inputs();
      ic_bus.resp_valid = 1'b1;
      settle();
      advance();
   endtask

   task automatic test_flush_drop();
      do_reset();
      fetch_req_addr[1] = 32'h0000_1040;
      fetch_req_valid   = 4'b0010;
      ic_bus.ready      = 1'b1;
      settle();
      total++;
      if (ic_bus.req_addr !== 32'h0000_1040 || fetch_req_ready !== 4'b0010) begin
         bad++;
         $display("[TB] FAIL flush_grant addr=%h ready=%b want 00001040/0010",
                  ic_bus.req_addr, fetch_req_ready);
      end
      advance();
      fetch_req_valid = '0;
      fetch_flush     = 4'b0010;
      settle();
      advance();
      fetch_flush       = '0;
      ic_bus.resp_valid = 1'b1;
      ic_bus.resp_instr = 32'hBAD0_BAD0;
      settle();
      total++;
      if (fetch_resp_valid !== 4'b0000 || act_vec !== e_vec) begin
         bad++;
         $display("[TB] FAIL flush_dropped rv=%b want=0000", fetch_resp_valid);
      end
      advance();
      fetch_req_valid = 4'b0010;
      settle();
      total++;
      if (fetch_req_ready !== 4'b0010 || fetch_resp_valid !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL flush_back_to_arb ready=%b rv=%b want 0010/0000",
                  fetch_req_ready, fetch_resp_valid);
      end
      advance();
      fetch_req_valid = '0;
      fetch_flush     = 4'b0010;
      settle();
      total++;
      if (fetch_resp_valid !== 4'b0000 || act_vec !== e_vec) begin
         bad++;
         $display("[TB] FAIL flush_same_cycle rv=%b want=0000", fetch_resp_valid);
      end
      advance();
      clear_inputs();
   endtask

   task automatic test_timeout();
      do_reset();
      fetch_req_valid = 4'b0001;
      ic_bus.ready    = 1'b1;
      settle();
      advance();
      fetch_req_valid = '0;
      for (int i = 0; i < TMO; i++) begin
         settle();
         total++;
         if (err_timeout !== (i == TMO - 1) || act_vec !== e_vec) begin
            bad++;
            $display("[TB] FAIL timeout_cycle%0d err=%b want=%b", i + 1, err_timeout, i == TMO - 1);
         end
         advance();
      end
      fetch_req_valid = 4'b0010;
      settle();
      total++;
      if (fetch_req_ready !== 4'b0010 || err_timeout !== 1'b0) begin
         bad++;
         $display("[TB] FAIL timeout_back_to_arb ready=%b err=%b want 0010/0",
                  fetch_req_ready, err_timeout);
      end
      advance();
      clear_inputs();
      ic_bus.resp_valid = 1'b1;
      settle();
      advance();
      clear_inputs();
   endtask

   task automatic test_flush_ineligible();
      do_reset();
      fetch_req_valid = 4'b1000;
      fetch_flush     = 4'b1000;
      ic_bus.ready    = 1'b1;
      settle();
      total++;
      if (ic_bus.req_valid !== 1'b0 || fetch_req_ready !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL flush_ineligible icv=%b ready=%b want 0/0000",
                  ic_bus.req_valid, fetch_req_ready);
      end
      advance();
      clear_inputs();
   endtask

   task automatic test_ic_not_ready();
      do_reset();
      fetch_req_valid = '1;
      for (int i = 0; i < 3; i++) begin
         settle();
         total++;
         if (ic_bus.req_valid !== 1'b0 || act_vec !== e_vec) begin
            bad++;
            $display("[TB] FAIL not_ready_cycle%0d icv=%b want=0", i, ic_bus.req_valid);
         end
         advance();
      end
      ic_bus.ready = 1'b1;
      settle();
      total++;
      if (fetch_req_ready !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL not_ready_ptr_kept ready=%b want=0001", fetch_req_ready);
      end
      advance();
      clear_inputs();
      ic_bus.resp_valid = 1'b1;
      settle();
      advance();
      clear_inputs();
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      fetch_req_valid = 4'b0100;
      ic_bus.ready    = 1'b1;
      settle();
      advance();
      fetch_req_valid = '0;
      settle();
      advance();
      rst_n = 1'b0;
      model_reset();
      settle();
      total++;
      if (act_vec !== e_vec) begin
         bad++;
         $display("[TB] FAIL reset_mid_wait_outputs got=%h want=%h", act_vec, e_vec);
      end
      advance();
      rst_n             = 1'b1;
      ic_bus.resp_valid = 1'b1;
      ic_bus.resp_instr = 32'h0BAD_F00D;
      settle();
      total++;
      if (fetch_resp_valid !== 4'b0000 || act_vec !== e_vec) begin
         bad++;
         $display("[TB] FAIL reset_late_resp rv=%b want=0000", fetch_resp_valid);
      end
      total++;
      if (stat_grants !== '0) begin
         bad++;
         $display("[TB] FAIL reset_mid_wait_stats got=%h want=0", stat_grants);
      end
      advance();
      clear_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst_n             = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
         if (!rst_n) model_reset();
         fetch_req_valid   = N'($urandom);
         fetch_flush       = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         for (int r = 0; r < N; r++) fetch_req_addr[PW'(r)] = $urandom;
         ic_bus.ready      = ($urandom_range(0, 3) != 0);
         ic_bus.resp_valid = ($urandom_range(0, 2) == 0);
         ic_bus.resp_hit   = 1'($urandom_range(0, 1));
         ic_bus.resp_instr = $urandom;
         settle();
         total++;
         if (act_vec !== e_vec) begin
            bad++;
            $display("[TB] FAIL random_cycle%0d got=%h want=%h", i, act_vec, e_vec);
         end
         total++;
         if (stat_grants !== e_stats) begin
            bad++;
            $display("[TB] FAIL random_stats%0d got=%h want=%h", i, stat_grants, e_stats);
         end
         advance();
      end
      rst_n = 1'b1;
      clear_inputs();
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      test_reset();
      test_rr_pair();
      test_back_to_back();
      test_flush_drop();
      test_timeout();
      test_flush_ineligible();
      test_ic_not_ready();
      test_reset_mid_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/l1i_fetch_arbiter.md
L1I_FETCH_ARBITER -- requirements
Module: l1i_fetch_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4; number of fetch requesters (warp fetch units), range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 256; max cycles from cache acceptance to response, range 4..65535.
REQ-003 clk  input  1  clock; all state on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 fetch_req_valid  input  NUM_REQ  per-requester fetch request.
REQ-006 fetch_req_addr  input  NUM_REQ x ADDR_WIDTH  per-requester fetch address; held stable while valid and not granted.
REQ-007 fetch_req_ready  output  NUM_REQ  one-hot grant; request i accepted when valid[i] and ready[i] are both high.
REQ-008 fetch_flush  input  NUM_REQ  per-requester cancel (branch redirect).
REQ-009 fetch_resp_valid  output  NUM_REQ  one-hot response strobe to the owning requester.
REQ-010 fetch_resp_instr  output  INSTR_WIDTH  response instruction, shared bus.
REQ-011 fetch_resp_hit  output  1  response was a cache hit.
REQ-012 ic_req_valid  output  1  request to the instruction cache.
REQ-013 ic_req_addr  output  ADDR_WIDTH  address to the cache.
REQ-014 ic_ready  input  1  cache idle; request accepted when ic_req_valid and ic_ready.
REQ-015 ic_resp_valid, ic_resp_hit  input  1 each  cache response strobe and hit flag.
REQ-016 ic_resp_instr  input  INSTR_WIDTH  cache response instruction.
REQ-017 err_timeout  output  1  one-cycle pulse on response timeout.
REQ-018 stat_grants  output  NUM_REQ x 32  per-requester grant counters (see Configuration).

Function
REQ-019 Two-state FSM: ARB and WAIT; one cache request outstanding at most.
REQ-020 ARB: eligible[i] = fetch_req_valid[i] and not fetch_flush[i]; when ic_ready and any eligible, ic_req_valid=1; winner is first eligible at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-021 ARB: ic_req_addr = winner's address; fetch_req_ready[winner]=1 only when ic_ready=1; no other ready bit is high; transition to WAIT the next cycle.
REQ-022 On grant: owner register <= winner, rr_ptr <= (winner+1) mod NUM_REQ, drop flag <= 0, timeout counter <= 0.
REQ-023 With no eligible requester, or ic_ready=0, ic_req_valid=0, all ready=0, rr_ptr unchanged.
REQ-024 WAIT: ic_req_valid=0, all ready=0; counter increments each cycle.
REQ-025 WAIT, ic_resp_valid=1: if drop=0, fetch_resp_valid[owner]=1 in the same cycle with instr/hit passed through combinationally; go to ARB.
REQ-026 WAIT, fetch_flush[owner]=1: drop <= 1; a response in the same cycle as the flush is suppressed.
REQ-027 WAIT, counter reaches TIMEOUT_CYCLES-1 without response: err_timeout pulses, no response forwarded, go to ARB.
REQ-028 ic_resp_valid while in ARB is ignored.
REQ-029 Minimum back-to-back throughput: 1 grant per 2 cycles given a 1-cycle cache hit.

Reset
REQ-030 Asynchronous reset: state=ARB, rr_ptr=0, owner=0, drop=0, counter=0, stat_grants=0.
REQ-031 During and after reset all outputs are 0 until the first qualifying cycle.
REQ-032 Reset in WAIT abandons the outstanding request; any later cache response is ignored (REQ-028).

Configuration
REQ-033 Macro FETCH_ARB_STATS_EN: when defined, stat_grants[i] increments by 1 per grant to i, wrapping at 2^32.
REQ-034 Without FETCH_ARB_STATS_EN: no counter registers exist and stat_grants is tied to 0.

Structure
REQ-035 pkg_opengpu holds NUM_FETCH_REQ (default 4), FETCH_TIMEOUT_CYCLES, and typedef fetch_arb_state_t {ARB, WAIT}.
REQ-036 Sub-module rr_arbiter: combinational round-robin pick (req vector, ptr in -> one-hot grant and index); instantiated once.

Verification
REQ-037 Reqs 0,2 valid, rr_ptr=0, ic_ready=1 -> grant 0 first; after its response, grant 2; rr_ptr=3.
REQ-038 All 4 requesters continuously valid, 1-cycle hits -> grant order 0,1,2,3,0; exactly one grant per 2 cycles.
REQ-039 Req 1 granted to addr 0x0000_1040; flush[1] in WAIT; response arrives -> fetch_resp_valid all 0, FSM returns to ARB.
REQ-040 Cache withholds response, TIMEOUT_CYCLES=8 -> err_timeout high exactly 8 cycles after grant, then ARB.
REQ-041 valid[3]=1, flush[3]=1 same cycle, no others valid -> no grant; ic_req_valid=0.
REQ-042 rst_n asserted mid-WAIT, then late ic_resp_valid -> no fetch_resp_valid; with FETCH_ARB_STATS_EN defined, stat_grants reads 0.
